// File: rtl/counter_defs.sv
// Shared definitions for the JK-based counters: the JK command encoding ({J,K})
// and the default counter geometry.
package counter_defs;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  localparam int DEFAULT_WIDTH   = 5;
  localparam int DEFAULT_MODULUS = 10;

  // Build a {J,K} command that forces a flip-flop to a given value.
  function automatic jk_cmd_t jk_force(input logic value);
    return value ? JK_SET : JK_RESET;
  endfunction

endpackage : counter_defs

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop: falling-edge clocked, asynchronous active-low clear,
// complementary outputs.
module jk_ff_sync
  import counter_defs::*;
(
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  // NOTE: state uses non-blocking assignments and the async clear sits in the
  // sensitivity list, so clearing never waits for a clock edge.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= 1'b0;
    end else begin
      case (jk_cmd_t'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule : jk_ff_sync

// File: rtl/jk_sync_up_counter.sv
// Synchronous modulo-MODULUS up counter built from JK flip-flops, with parallel
// load, count enable, cascadable terminal count, wrap pulse and sticky load error.
module jk_sync_up_counter
  import counter_defs::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_sync_up_counter: MODULUS must lie in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] d_eff;
  jk_cmd_t          cmd [WIDTH];
  logic             d_in_range;
  logic             at_last;
  logic             terminal;
  logic             wrap_next;

  // Decode: range check on the load value, terminal detection on the count.
  // Anything at or above LAST counts as terminal so stray states recover by
  // wrapping to 0; tc itself only reports the exact last value.
  always_comb begin
    d_in_range = ({1'b0, d} < MOD_EXT);
    d_eff      = d_in_range ? d : '0;
    at_last    = &((q & LAST) | (q_bar & ~LAST));
    terminal   = (q >= LAST);
    tc         = en & ~load & at_last;
    wrap_next  = ~load & en & terminal;
  end

  // Ripple-free carry: bit i toggles when every lower bit is 1.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = carry;
      carry     = carry & q[i];
    end
  end

  // NOTE: every output of this block is given a value on every path (the HOLD
  // default first), so no latch is inferred.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i] = JK_HOLD;
      if (load) begin
        cmd[i] = jk_force(d_eff[i]);
      end else if (en) begin
        if (terminal) begin
          cmd[i] = JK_RESET;
        end else if (toggle[i]) begin
          cmd[i] = JK_TOGGLE;
        end
      end
      j[i] = cmd[i][1];
      k[i] = cmd[i][0];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_ff (
      .clk   (clk),
      .clr_n (clr_n),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap <= wrap_next;
      if (load) begin
        load_err <= ~d_in_range;
      end
    end
  end

endmodule : jk_sync_up_counter

// File: doc/jk_sync_up_counter.md
# jk_sync_up_counter

Synchronous modulo-N up counter built from JK flip-flops sharing a single clock. It is the counting-up counterpart of the team's ripple down counter. It provides parallel load, count enable, and a cascadable terminal-count output so that several stages can chain into multi-digit up counters. Typical use is the BCD/event-count datapaths in the ED13 exercise set.

## Interface
- WIDTH, 5, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal values are 2..2^WIDTH.
- clk  input  1  clock; all state updates on the falling edge.
- clr_n  input  1  reset, asynchronous, active-low.
- en  input  1  count enable, sampled on the falling edge of clk.
- load  input  1  synchronous parallel load, sampled on the falling edge of clk.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count.
- tc  output  1  terminal count, combinational: en & ~load & (q == MODULUS-1).
- wrap  output  1  registered pulse, high for one clk period after a wrap to 0.
- load_err  output  1  sticky flag set when an out-of-range load value is loaded.

## Operation
- Priority per falling edge: clr_n low > load > en > hold.
- clr_n low, at any time: q=0, wrap=0, load_err=0 immediately, independent of clk. Release is synchronous to the next falling edge; the first update occurs on the first falling edge after release.
- load=1:
  - d < MODULUS: q=d and load_err=0.
  - d >= MODULUS: q=0 and load_err=1.
  - wrap=0 in both cases.
  - en is ignored in a load cycle.
- load=0, en=1:
  - q < MODULUS-1: q=q+1, wrap=0.
  - q == MODULUS-1: q=0, wrap=1.
- load=0, en=0: q and load_err hold; wrap=0.
- Any q >= MODULUS reached by other means (X, glitch) is treated as MODULUS-1 by the next enabled count, so the counter wraps to 0 and asserts wrap.
- Arithmetic is unsigned, WIDTH bits. MODULUS = 2^WIDTH gives the natural roll-over 2^WIDTH-1 -> 0 with wrap=1.
- Per-bit JK drive:
  - Count: J=K=toggle_i, where toggle_i = AND of q[i-1:0] (standard synchronous up counter). At terminal count, J=0 and K=1 for every bit.
  - Load: J=d_eff[i], K=~d_eff[i].
  - Hold: J=K=0.
- Cascading: drive the next stage's en from this stage's tc. Stages share clk and clr_n.

## Timing
- Reset values: q=0, tc=0 (because q≠MODULUS-1 or en=0), wrap=0, load_err=0.
- Latency is one clk falling edge from sampled en/load/d to q.
- tc is combinational from q, en and load, and is valid before the next falling edge. There is no registered delay, so chained stages advance in the same edge.
- wrap is asserted in the period following the wrapping edge and cleared on the next falling edge unless another wrap occurs. With MODULUS=1 behaviour undefined; MODULUS=2 with en held high gives wrap every second period.
- load and en both high in the same cycle: load wins and wrap=0.
- clr_n asserted mid-count: outputs are cleared within the same period. No partial update occurs on a coincident falling edge.

## Structure
- Shared package/include counter_defs holds:
  - JK command constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Default WIDTH and MODULUS.
- One sub-module, jk_ff_sync: a single JK flip-flop with
  - falling-edge clk;
  - asynchronous active-low clr_n only (no preset);
  - outputs q and q_bar.
- The top instantiates WIDTH of these plus the next-state J/K logic, the wrap register and the load_err register.

## Test plan
- Reset mid-count: count to 6, pulse clr_n low between edges -> q=0, wrap=0, load_err=0 immediately. After release with en=1, next edge gives q=1.
- Full cycle, MODULUS=10, en=1 from q=0: q steps 0..9. tc=1 only while q=9; next edge gives q=0 with wrap=1 for exactly one period.
- Load, then count: load=1, d=7 -> q=7, load_err=0. Then en=1 gives 8, 9, 0 with wrap after the third edge.
- Out-of-range load: d=12 with MODULUS=10 -> q=0, load_err=1. A subsequent load of d=3 -> q=3, load_err=0.
- Simultaneous load and en at q=9: d=4 -> q=4, wrap=0, tc=0 during the load cycle.
- Cascade and full roll-over: two instances, MODULUS=10, tens.en=units.tc. Counting from 00 reaches 99, then 00 with units.wrap=1 and tens.wrap=1 on the same edge. Separately, WIDTH=5, MODULUS=32: 31 -> 0 with wrap=1.
